mc_ctrl_fsm: RTL
================

Name: mc_ctrl_fsm

Overview:
- Main control unit for the multicycle MIPS datapath: a Moore FSM that sequences fetch, decode, execute, memory and writeback for each instruction.
- Drives every datapath select and write strobe (PC, IR, register file, data memory, ALU).
- Stalls on a memory-ready handshake.
- Sits beside the datapath; its only inputs are instruction opcode/funct, ALU zero and memory ready.

Parameters:
- OP_W, 6, opcode field width
- FN_W, 6, funct field width
- ALUC_W, 3, ALU control code width

Ports:
- clk  in  1  system clock, rising edge
- reset  in  1  asynchronous, active-low reset
- opcode  in  6  instruction[31:26] from IR
- funct  in  6  instruction[5:0] from IR
- zero  in  1  ALU zero flag
- mem_ready  in  1  unified memory has completed the current access
- iord  out  1  0 = memory address from PC, 1 = from ALUOut
- mem_read  out  1  memory read request
- mem_write  out  1  memory write strobe
- ir_write  out  1  IR load enable
- reg_dst  out  1  0 = rt, 1 = rd
- mem_to_reg  out  1  0 = ALUOut, 1 = memory data register
- reg_write  out  1  register file write enable
- alu_src_a  out  1  0 = PC, 1 = A
- alu_src_b  out  2  00 = B, 01 = const 4, 10 = sign-extended imm, 11 = sign-extended imm << 2
- alu_ctl  out  3  ALU operation code
- pc_src  out  2  00 = ALU result, 01 = ALUOut, 10 = jump target {PC[31:28], JTA, 2'b00}
- pc_en  out  1  PC load enable = pc_write | (branch & zero)
- illegal_op  out  1  one-cycle pulse on an unsupported opcode
- state_dbg  out  4  current state encoding, for the monitor

Behaviour:
- Reset:
  - Asserting reset low forces state to FETCH asynchronously.
  - While reset is low, all strobes are 0 (mem_read, mem_write, ir_write, reg_write, pc_en, illegal_op) and all selects are 0.
  - After deassertion, the first rising edge evaluates FETCH.
- Encoding: FETCH = 0, DECODE = 1, MEMADR = 2, MEMRD = 3, MEMWB = 4, MEMWR = 5, RTEXEC = 6, ALUWB = 7, BRANCH = 8, ADDIEX = 9, ADDIWB = 10, JUMP = 11. Codes 12-15 are illegal.
- Outputs are pure decode of state plus mem_ready/zero. No registered outputs.
- FETCH:
  - Drives iord = 0, mem_read = 1, alu_src_a = 0, alu_src_b = 01, alu_ctl = ADD, pc_src = 00.
  - ir_write and pc_write are asserted only while mem_ready = 1.
  - Stays in FETCH while mem_ready = 0; goes to DECODE when mem_ready = 1.
- DECODE:
  - Drives alu_src_a = 0, alu_src_b = 11, alu_ctl = ADD (precomputes the branch target).
  - Next state by opcode: 0x23 or 0x2B -> MEMADR; 0x00 -> RTEXEC; 0x04 -> BRANCH; 0x08 -> ADDIEX; 0x02 -> JUMP.
  - Any other opcode -> FETCH with illegal_op = 1 for this cycle. PC has already advanced, so the instruction is skipped.
- MEMADR: alu_src_a = 1, alu_src_b = 10, alu_ctl = ADD. Opcode 0x23 -> MEMRD; 0x2B -> MEMWR.
- MEMRD: iord = 1, mem_read = 1. Holds while mem_ready = 0, then -> MEMWB.
- MEMWB: reg_dst = 0, mem_to_reg = 1, reg_write = 1 -> FETCH.
- MEMWR: iord = 1. mem_write is asserted for every cycle in this state. Holds until mem_ready = 1 -> FETCH.
- RTEXEC:
  - alu_src_a = 1, alu_src_b = 00, alu_ctl from funct: 0x20 ADD = 010, 0x22 SUB = 110, 0x24 AND = 000, 0x25 OR = 001, 0x2A SLT = 111.
  - Unknown funct: alu_ctl = ADD, illegal_op pulses, next state FETCH (no writeback).
  - Known funct -> ALUWB.
- ALUWB: reg_dst = 1, mem_to_reg = 0, reg_write = 1 -> FETCH.
- BRANCH: alu_src_a = 1, alu_src_b = 00, alu_ctl = SUB, branch = 1, pc_src = 01. pc_en = zero. -> FETCH.
- ADDIEX: alu_src_a = 1, alu_src_b = 10, alu_ctl = ADD -> ADDIWB.
- ADDIWB: reg_dst = 0, mem_to_reg = 0, reg_write = 1 -> FETCH.
- JUMP: pc_src = 10, pc_write = 1 -> FETCH.
- Illegal state codes 12-15 -> FETCH on the next edge, all strobes 0.
- Latency with mem_ready held at 1: lw 5, sw 4, R-type 4, addi 4, beq 3, j 3 cycles.
- Reset mid-instruction aborts immediately; no partial writeback occurs after reset assertion.
- mem_ready is sampled only in FETCH, MEMRD and MEMWR; it is ignored elsewhere.

Decomposition:
- Package mc_ctrl_pkg holds:
  - state_t enum
  - opcode localparams (OP_RTYPE, OP_LW, OP_SW, OP_BEQ, OP_ADDI, OP_J)
  - funct localparams
  - ALU control codes (ALU_ADD, ALU_SUB, ALU_AND, ALU_OR, ALU_SLT)
  - alu_src_b and pc_src select encodings
- Sub-module mc_alu_dec: combinational, (alu_op[1:0], funct) -> alu_ctl and funct_ok. It is instantiated by the FSM.

Test Plan:
- Reset low mid-MEMRD, then release -> state_dbg = 0 immediately; no reg_write asserted; first cycle after release shows mem_read = 1, iord = 0.
- lw (opcode 0x23), mem_ready = 1 -> states 0, 1, 2, 3, 4; reg_write = 1 only in cycle 5 with mem_to_reg = 1; pc_en = 1 only in cycle 1.
- sw (0x2B), mem_ready low for 3 cycles in MEMWR -> mem_write high for 4 consecutive cycles; then FETCH.
- beq (0x04): zero = 1 -> pc_en = 1, pc_src = 01 in BRANCH; repeat with zero = 0 -> pc_en = 0; both return to FETCH after 3 cycles.
- R-type with funct 0x2A -> alu_ctl = 111 in RTEXEC, reg_dst = 1 in ALUWB; funct 0x3F -> illegal_op pulse, no reg_write.
- Opcode 0x3F -> illegal_op = 1 in DECODE, next state FETCH; j (0x02) -> pc_src = 10, pc_en = 1 in JUMP.

Source files
------------

// File: rtl/mc_ctrl_pkg.sv
// Shared types and encodings for the multicycle MIPS control unit.
// State codes are exported on state_dbg, so their values are fixed.
package mc_ctrl_pkg;

   typedef enum logic [3:0] {
      S_FETCH  = 4'd0,
      S_DECODE = 4'd1,
      S_MEMADR = 4'd2,
      S_MEMRD  = 4'd3,
      S_MEMWB  = 4'd4,
      S_MEMWR  = 4'd5,
      S_RTEXEC = 4'd6,
      S_ALUWB  = 4'd7,
      S_BRANCH = 4'd8,
      S_ADDIEX = 4'd9,
      S_ADDIWB = 4'd10,
      S_JUMP   = 4'd11
   } state_t;

   localparam logic [5:0] OP_RTYPE = 6'h00;
   localparam logic [5:0] OP_LW    = 6'h23;
   localparam logic [5:0] OP_SW    = 6'h2B;
   localparam logic [5:0] OP_BEQ   = 6'h04;
   localparam logic [5:0] OP_ADDI  = 6'h08;
   localparam logic [5:0] OP_J     = 6'h02;

   localparam logic [5:0] FN_ADD = 6'h20;
   localparam logic [5:0] FN_SUB = 6'h22;
   localparam logic [5:0] FN_AND = 6'h24;
   localparam logic [5:0] FN_OR  = 6'h25;
   localparam logic [5:0] FN_SLT = 6'h2A;

   localparam logic [2:0] ALU_ADD = 3'b010;
   localparam logic [2:0] ALU_SUB = 3'b110;
   localparam logic [2:0] ALU_AND = 3'b000;
   localparam logic [2:0] ALU_OR  = 3'b001;
   localparam logic [2:0] ALU_SLT = 3'b111;

   // ALU operation class requested by the FSM from the ALU decoder
   localparam logic [1:0] ALUOP_ADD   = 2'b00;
   localparam logic [1:0] ALUOP_SUB   = 2'b01;
   localparam logic [1:0] ALUOP_FUNCT = 2'b10;

   localparam logic [1:0] SRCB_B      = 2'b00;
   localparam logic [1:0] SRCB_FOUR   = 2'b01;
   localparam logic [1:0] SRCB_IMM    = 2'b10;
   localparam logic [1:0] SRCB_IMM_S2 = 2'b11;

   localparam logic [1:0] PCSRC_ALU    = 2'b00;
   localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
   localparam logic [1:0] PCSRC_JUMP   = 2'b10;

endpackage

// File: rtl/mc_alu_dec.sv
// ALU control decoder: maps the FSM's ALU operation class and the R-type
// funct field to an ALU control code, flagging unsupported funct values.
module mc_alu_dec
   import mc_ctrl_pkg::*;
#(
   parameter int FN_W   = 6,
   parameter int ALUC_W = 3
) (
   input  logic [1:0]        alu_op,
   input  logic [FN_W-1:0]   funct,
   output logic [ALUC_W-1:0] alu_ctl,
   output logic              funct_ok
);

   always_comb begin
      alu_ctl  = ALU_ADD;
      funct_ok = 1'b1;
      case (alu_op)
         ALUOP_SUB: alu_ctl = ALU_SUB;
         ALUOP_FUNCT: begin
            case (funct)
               FN_ADD:  alu_ctl = ALU_ADD;
               FN_SUB:  alu_ctl = ALU_SUB;
               FN_AND:  alu_ctl = ALU_AND;
               FN_OR:   alu_ctl = ALU_OR;
               FN_SLT:  alu_ctl = ALU_SLT;
               default: begin
                  alu_ctl  = ALU_ADD;
                  funct_ok = 1'b0;
               end
            endcase
         end
         default: alu_ctl = ALU_ADD;
      endcase
   end

endmodule

// File: rtl/mc_ctrl_fsm.sv
// Moore control FSM for the multicycle MIPS datapath. Outputs decode the
// current state (plus mem_ready/zero) and are forced to zero while in reset.
module mc_ctrl_fsm
   import mc_ctrl_pkg::*;
#(
   parameter int OP_W   = 6,
   parameter int FN_W   = 6,
   parameter int ALUC_W = 3
) (
   input  logic              clk,
   input  logic              reset,
   input  logic [OP_W-1:0]   opcode,
   input  logic [FN_W-1:0]   funct,
   input  logic              zero,
   input  logic              mem_ready,
   output logic              iord,
   output logic              mem_read,
   output logic              mem_write,
   output logic              ir_write,
   output logic              reg_dst,
   output logic              mem_to_reg,
   output logic              reg_write,
   output logic              alu_src_a,
   output logic [1:0]        alu_src_b,
   output logic [ALUC_W-1:0] alu_ctl,
   output logic [1:0]        pc_src,
   output logic              pc_en,
   output logic              illegal_op,
   output logic [3:0]        state_dbg
);

   state_t              state_reg;
   state_t              state_next;
   logic [1:0]          alu_op;
   logic [ALUC_W-1:0]   alu_ctl_dec;
   logic                funct_ok;
   logic                pc_write;
   logic                branch;

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_reg <= S_FETCH;
      end else begin
         state_reg <= state_next;
      end
   end

   // Kept apart from the main decode so funct_ok feeds back without a comb loop
   always_comb begin
      alu_op = ALUOP_ADD;
      if (state_reg == S_RTEXEC) begin
         alu_op = ALUOP_FUNCT;
      end else if (state_reg == S_BRANCH) begin
         alu_op = ALUOP_SUB;
      end
   end

   mc_alu_dec #(
      .FN_W   (FN_W),
      .ALUC_W (ALUC_W)
   ) u_alu_dec (
      .alu_op   (alu_op),
      .funct    (funct),
      .alu_ctl  (alu_ctl_dec),
      .funct_ok (funct_ok)
   );

   always_comb begin
      state_next = state_reg;
      iord       = 1'b0;
      mem_read   = 1'b0;
      mem_write  = 1'b0;
      ir_write   = 1'b0;
      reg_dst    = 1'b0;
      mem_to_reg = 1'b0;
      reg_write  = 1'b0;
      alu_src_a  = 1'b0;
      alu_src_b  = SRCB_B;
      alu_ctl    = '0;
      pc_src     = PCSRC_ALU;
      pc_write   = 1'b0;
      branch     = 1'b0;
      illegal_op = 1'b0;

      if (reset) begin
         case (state_reg)
            S_FETCH: begin
               mem_read  = 1'b1;
               alu_src_b = SRCB_FOUR;
               alu_ctl   = alu_ctl_dec;
               if (mem_ready) begin
                  ir_write   = 1'b1;
                  pc_write   = 1'b1;
                  state_next = S_DECODE;
               end
            end
            S_DECODE: begin
               alu_src_b = SRCB_IMM_S2;
               alu_ctl   = alu_ctl_dec;
               case (opcode)
                  OP_LW, OP_SW: state_next = S_MEMADR;
                  OP_RTYPE:     state_next = S_RTEXEC;
                  OP_BEQ:       state_next = S_BRANCH;
                  OP_ADDI:      state_next = S_ADDIEX;
                  OP_J:         state_next = S_JUMP;
                  default: begin
                     // PC already advanced in FETCH, so the word is skipped
                     illegal_op = 1'b1;
                     state_next = S_FETCH;
                  end
               endcase
            end
            S_MEMADR: begin
               alu_src_a  = 1'b1;
               alu_src_b  = SRCB_IMM;
               alu_ctl    = alu_ctl_dec;
               state_next = (opcode == OP_SW) ? S_MEMWR : S_MEMRD;
            end
            S_MEMRD: begin
               iord     = 1'b1;
               mem_read = 1'b1;
               if (mem_ready) begin
                  state_next = S_MEMWB;
               end
            end
            S_MEMWB: begin
               mem_to_reg = 1'b1;
               reg_write  = 1'b1;
               state_next = S_FETCH;
            end
            S_MEMWR: begin
               iord      = 1'b1;
               mem_write = 1'b1;
               if (mem_ready) begin
                  state_next = S_FETCH;
               end
            end
            S_RTEXEC: begin
               alu_src_a = 1'b1;
               alu_src_b = SRCB_B;
               alu_ctl   = alu_ctl_dec;
               if (funct_ok) begin
                  state_next = S_ALUWB;
               end else begin
                  illegal_op = 1'b1;
                  state_next = S_FETCH;
               end
            end
            S_ALUWB: begin
               reg_dst    = 1'b1;
               reg_write  = 1'b1;
               state_next = S_FETCH;
            end
            S_BRANCH: begin
               alu_src_a  = 1'b1;
               alu_src_b  = SRCB_B;
               alu_ctl    = alu_ctl_dec;
               branch     = 1'b1;
               pc_src     = PCSRC_ALUOUT;
               state_next = S_FETCH;
            end
            S_ADDIEX: begin
               alu_src_a  = 1'b1;
               alu_src_b  = SRCB_IMM;
               alu_ctl    = alu_ctl_dec;
               state_next = S_ADDIWB;
            end
            S_ADDIWB: begin
               reg_write  = 1'b1;
               state_next = S_FETCH;
            end
            S_JUMP: begin
               pc_src     = PCSRC_JUMP;
               pc_write   = 1'b1;
               state_next = S_FETCH;
            end
            default: state_next = S_FETCH;
         endcase
      end

      pc_en = pc_write | (branch & zero);
   end

   assign state_dbg = state_reg;

endmodule
